lsu_ctrl: RTL and testbench



---
 rtl/lsu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes a memory instruction, runs one req/ready transaction
// on the data port, returns extended load data with a done pulse and an error code.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [1:0] ErrOk   = 2'b00;
  localparam logic [1:0] ErrMis  = 2'b01;
  localparam logic [1:0] ErrIll  = 2'b10;
  localparam logic [1:0] ErrTmo  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FIN = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        legal, misal;
  logic [1:0]  dec_err;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_ir;

  assign unused_ir = ^{ir_i[31:15], ir_i[11:7]};

  always_comb begin
    opcode   = ir_i[6:0];
    funct3   = ir_i[14:12];
    off      = addr_i[1:0];
    legal    = 1'b0;
    if (opcode == OpLoad) begin
      legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end else if (opcode == OpStore) begin
      legal = !funct3[2] && (funct3[1:0] != 2'b11);
    end
    misal    = ((funct3[1:0] == 2'b01) && off[0]) ||
               ((funct3[1:0] == 2'b10) && (off != 2'b00));
    dec_err  = !legal ? ErrIll : (misal ? ErrMis : ErrOk);
    st_wdata = wdata_i;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata_i[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{wdata_i[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at start, not the live address.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          we_d    = (opcode == OpStore);
          f3_d    = funct3;
          off_d   = off;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = (opcode == OpStore) ? st_wstrb : 4'b0000;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          err_d   = dec_err;
          state_d = (dec_err == ErrOk) ? REQ : FIN;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == MaxWait) begin
            err_d   = ErrTmo;
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      err_q   <= ErrOk;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs are qualified by the state register so they read zero outside REQ.
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? addr_q : 32'd0;
  assign mem_wdata_o = mem_req_o ? wdata_q : 32'd0;
  assign mem_wstrb_o = mem_req_o ? wstrb_q : 4'd0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FIN);
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a transaction-level reference model.
module tb_lsu_ctrl;
  localparam int MAXW = 4;

  logic        clk, rst_n, start;
  logic [31:0] ir, addr, wdata, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  err;

  lsu_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ir_i(ir), .addr_i(addr),
    .wdata_i(wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .busy_o(busy),
    .done_o(done), .err_o(err), .rdata_o(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic        exp_busy, exp_done, exp_req, exp_we;
  logic [1:0]  exp_err;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  int          req_cnt;
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic [1:0]  cap_err;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("done", 32'(done), 32'(exp_done));
      cmp("mem_req", 32'(mem_req), 32'(exp_req));
      cmp("err", 32'(err), 32'(exp_err));
      cmp("rdata", rdata, exp_rdata);
      if (exp_req) begin
        cmp("mem_we", 32'(mem_we), 32'(exp_we));
        cmp("mem_addr", mem_addr, exp_addr);
        cmp("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
        if (exp_we) cmp("mem_wdata", mem_wdata, exp_wdata);
      end
    end
    if (mem_req) begin
      req_cnt++;
      cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
    end
    if (done) begin
      cap_rdata = rdata; cap_err = err;
    end
  end

  // Reference model: what one instruction must do, from the ISA-level rules.
  task automatic model(input logic [31:0] m_ir, input logic [31:0] m_addr,
                       input logic [31:0] m_wdata, input logic [31:0] m_rword,
                       output logic [1:0] code, output bit is_st, output logic [31:0] ld_val,
                       output logic [31:0] st_dat, output logic [3:0] st_stb);
    int f3, off, size;
    bit uns, legal;
    logic [31:0] sh;
    f3 = int'(m_ir[14:12]); off = int'(m_addr[1:0]); size = f3 % 4; uns = (f3 >= 4);
    is_st = (m_ir[6:0] == 7'h23);
    if (m_ir[6:0] == 7'h03) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else if (is_st)          legal = (f3 <= 2);
    else                     legal = 1'b0;
    if (!legal) code = 2'd2;
    else if ((size == 1 && off % 2 == 1) || (size == 2 && off != 0)) code = 2'd1;
    else code = 2'd0;
    sh = m_rword >> (8 * off);
    ld_val = m_rword; st_dat = m_wdata; st_stb = 4'hF;
    if (size == 0) begin
      ld_val = sh & 32'hFF;
      if (!uns && ld_val >= 32'd128) ld_val = ld_val - 32'd256;
      st_dat = (m_wdata & 32'hFF) * 32'h0101_0101;
      st_stb = 4'(1 << off);
    end else if (size == 1) begin
      ld_val = sh & 32'hFFFF;
      if (!uns && ld_val >= 32'd32768) ld_val = ld_val - 32'd65536;
      st_dat = (m_wdata & 32'hFFFF) * 32'h0001_0001;
      st_stb = 4'(3 << off);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] v;
    v = $urandom; v[6:0] = op; v[14:12] = f3;
    return v;
  endfunction

  task automatic set_exp(input logic b, input logic d, input logic q, input logic [1:0] e,
                         input logic [31:0] r);
    exp_busy = b; exp_done = d; exp_req = q; exp_err = e; exp_rdata = r;
  endtask

  task automatic scramble(input bit noise);
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    ir = $urandom; addr = $urandom; wdata = $urandom;
  endtask

  task automatic run_txn(input logic [31:0] t_ir, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input logic [31:0] t_rword,
                         input int w, input bit noise);
    logic [1:0] code; bit st; logic [31:0] ldv, sdat; logic [3:0] sstb; int n;
    model(t_ir, t_addr, t_wdata, t_rword, code, st, ldv, sdat, sstb);
    @(negedge clk);
    start = 1'b1; ir = t_ir; addr = t_addr; wdata = t_wdata;
    mem_ready = 1'b0; mem_rdata = $urandom; req_cnt = 0;
    exp_we = st; exp_addr = t_addr & 32'hFFFF_FFFC; exp_wdata = sdat;
    exp_wstrb = st ? sstb : 4'h0;
    if (code != 2'd0) set_exp(1, 1, 0, code, 32'd0);
    else              set_exp(1, 0, 1, 2'd0, 32'd0);
    if (code == 2'd0) begin
      n = (w < MAXW) ? w + 1 : MAXW;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        scramble(noise);
        mem_ready = (i == w);
        mem_rdata = (i == w) ? t_rword : $urandom;
        if (i == n - 1) begin
          if (w < MAXW) set_exp(1, 1, 0, 2'd0, st ? 32'd0 : ldv);
          else          set_exp(1, 1, 0, 2'd3, 32'd0);
        end
      end
    end
    @(negedge clk);
    scramble(noise);
    mem_ready = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; ir = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0; req_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_mem_req", 32'(mem_req), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_err", 32'(err), 32'd0);
    cmp("rst_rdata", rdata, 32'd0);
    cmp("rst_mem_addr", mem_addr, 32'd0);
    cmp("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_exp(0, 0, 0, 2'd0, 32'd0);
    exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
    chk_en = 1'b1;
    idle_cyc(1);

    run_txn(mk_ir(7'h03, 3'd0), 32'h0000_1001, 32'h0, 32'h0000_A500, 0, 0);
    cmp("lit_lb_rdata", cap_rdata, 32'hFFFF_FFA5);
    cmp("lit_lb_err", 32'(cap_err), 32'd0);
    cmp("lit_lb_reqcnt", 32'(req_cnt), 32'd1);
    cmp("lit_lb_addr", cap_addr, 32'h0000_1000);
    cmp("lit_lb_wstrb", 32'(cap_wstrb), 32'd0);
    run_txn(mk_ir(7'h03, 3'd4), 32'h0000_1001, 32'h0, 32'h0000_A500, 0, 0);
    cmp("lit_lbu_rdata", cap_rdata, 32'h0000_00A5);
    run_txn(mk_ir(7'h23, 3'd1), 32'h0000_2002, 32'h1234_BEEF, 32'hFFFF_FFFF, 0, 1);
    cmp("lit_sh_we", 32'(cap_we), 32'd1);
    cmp("lit_sh_wstrb", 32'(cap_wstrb), 32'hC);
    cmp("lit_sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    cmp("lit_sh_rdata", cap_rdata, 32'd0);
    run_txn(mk_ir(7'h03, 3'd2), 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3, 1);
    cmp("lit_lw_reqcnt", 32'(req_cnt), 32'd4);
    cmp("lit_lw_rdata", cap_rdata, 32'hDEAD_BEEF);
    run_txn(mk_ir(7'h03, 3'd2), 32'h0000_3002, 32'h0, 32'h1111_1111, 0, 0);
    cmp("lit_mis_err", 32'(cap_err), 32'd1);
    cmp("lit_mis_reqcnt", 32'(req_cnt), 32'd0);
    run_txn(mk_ir(7'h03, 3'd3), 32'h0000_3000, 32'h0, 32'h1111_1111, 0, 0);
    cmp("lit_ill_err", 32'(cap_err), 32'd2);
    cmp("lit_ill_rdata", cap_rdata, 32'd0);
    run_txn(mk_ir(7'h23, 3'd2), 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 10, 1);
    cmp("lit_tmo_reqcnt", 32'(req_cnt), 32'd4);
    cmp("lit_tmo_err", 32'(cap_err), 32'd3);
    idle_cyc(1);

    // Reset in the middle of a load: outputs must clear without a clock edge.
    @(negedge clk);
    start = 1'b1; ir = mk_ir(7'h03, 3'd2); addr = 32'h0000_0200; mem_ready = 1'b0;
    req_cnt = 0;
    exp_we = 0; exp_addr = 32'h0000_0200; exp_wstrb = 0;
    set_exp(1, 0, 1, 2'd0, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    set_exp(0, 0, 0, 2'd0, 32'd0);
    #1;
    cmp("rstmid_mem_req", 32'(mem_req), 32'd0);
    cmp("rstmid_busy", 32'(busy), 32'd0);
    cmp("rstmid_mem_addr", mem_addr, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    idle_cyc(1);
    run_txn(mk_ir(7'h03, 3'd5), 32'h0000_4002, 32'h0, 32'h8001_1234, 1, 0);
    cmp("lit_lhu_rdata", cap_rdata, 32'h0000_8001);
    cmp("lit_lhu_err", 32'(cap_err), 32'd0);

    for (int k = 0; k < 250; k++) begin
      int r;
      logic [31:0] tmp;
      logic [6:0] op;
      r = $urandom_range(0, 9);
      tmp = $urandom;
      op = (r < 4) ? 7'h03 : ((r < 8) ? 7'h23 : tmp[6:0]);
      run_txn(mk_ir(op, 3'($urandom_range(0, 7))), $urandom, $urandom, $urandom,
              $urandom_range(0, 5), 1);
      idle_cyc($urandom_range(0, 2));
    end

    idle_cyc(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
